// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle IF/ID/EX/MEM/WB control FSM with registered control word
module multicycle_control #(
   parameter int NR_REGS       = 16,
   parameter bit ENABLE_SYSTEM = 1'b1,
   parameter int MEM_TIMEOUT   = 255
) (
   input  logic        clk,
   input  logic        rst,
   output logic        ifu_req,
   input  logic        ifu_valid,
   input  logic [31:0] ifu_inst,
   output logic        lsu_req,
   input  logic        lsu_done,
   output logic        reg_write,
   output logic        pc_we,
   output logic        mem_read,
   output logic        mem_write,
   output logic        mem_to_reg,
   output logic        alu_src,
   output logic [3:0]  alu_op,
   output logic        branch,
   output logic        jump,
   output logic        halted,
   output logic        illegal,
   output logic        bus_err,
   output logic [31:0] instret
);

   localparam logic [2:0] S_IF   = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EX   = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_HALT = 3'd5;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_OR   = 4'd8;
   localparam logic [3:0] ALU_AND  = 4'd9;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
   localparam logic [5:0]  REG_LIMIT   = 6'(NR_REGS);
   localparam logic [7:0]  TMO_LAST    = 8'(MEM_TIMEOUT - 1);

   logic [2:0]  state_q, state_d;
   logic [31:0] inst_q;
   logic [7:0]  tmo_q, tmo_d;
   logic        illegal_q, illegal_d;
   logic        bus_err_q, bus_err_d;
   logic [31:0] instret_q, instret_d;

   // registered control word
   logic        rw_q, mem_read_q, mem_write_q, mem_to_reg_q, alu_src_q, branch_q, jump_q;
   logic [3:0]  alu_op_q;

   // combinational decode of inst_q
   logic        dec_rw, dec_mem_read, dec_mem_write, dec_mem_to_reg, dec_alu_src;
   logic        dec_branch, dec_jump, dec_ebreak, dec_bad_enc, dec_illegal;
   logic        use_rd, use_rs1, use_rs2;
   logic [3:0]  dec_alu_op;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [4:0]  rd, rs1, rs2;

   assign opcode = inst_q[6:0];
   assign rd     = inst_q[11:7];
   assign funct3 = inst_q[14:12];
   assign rs1    = inst_q[19:15];
   assign rs2    = inst_q[24:20];
   assign funct7 = inst_q[31:25];

   // funct3 to ALU operation; alt picks SUB over ADD and SRA over SRL
   function automatic logic [3:0] f3_to_alu(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  f3_to_alu = alt ? ALU_SUB : ALU_ADD;
         3'b001:  f3_to_alu = ALU_SLL;
         3'b010:  f3_to_alu = ALU_SLT;
         3'b011:  f3_to_alu = ALU_SLTU;
         3'b100:  f3_to_alu = ALU_XOR;
         3'b101:  f3_to_alu = alt ? ALU_SRA : ALU_SRL;
         3'b110:  f3_to_alu = ALU_OR;
         default: f3_to_alu = ALU_AND;
      endcase
   endfunction

   // decode the captured instruction into a candidate control word and legality flags
   always_comb begin
      dec_rw         = 1'b0;
      dec_mem_read   = 1'b0;
      dec_mem_write  = 1'b0;
      dec_mem_to_reg = 1'b0;
      dec_alu_src    = 1'b0;
      dec_branch     = 1'b0;
      dec_jump       = 1'b0;
      dec_alu_op     = ALU_ADD;
      dec_ebreak     = 1'b0;
      dec_bad_enc    = 1'b0;
      use_rd         = 1'b0;
      use_rs1        = 1'b0;
      use_rs2        = 1'b0;
      case (opcode)
         OPC_LUI, OPC_AUIPC: begin
            dec_rw      = 1'b1;
            dec_alu_src = 1'b1;
            use_rd      = 1'b1;
         end
         OPC_JAL: begin
            dec_rw   = 1'b1;
            dec_jump = 1'b1;
            use_rd   = 1'b1;
         end
         OPC_JALR: begin
            dec_rw      = 1'b1;
            dec_alu_src = 1'b1;
            dec_jump    = 1'b1;
            use_rd      = 1'b1;
            use_rs1     = 1'b1;
         end
         OPC_LOAD: begin
            dec_rw         = 1'b1;
            dec_mem_read   = 1'b1;
            dec_mem_to_reg = 1'b1;
            dec_alu_src    = 1'b1;
            use_rd         = 1'b1;
            use_rs1        = 1'b1;
            dec_bad_enc    = (funct3 == 3'b011) || (funct3 >= 3'b110);
         end
         OPC_STORE: begin
            dec_mem_write = 1'b1;
            dec_alu_src   = 1'b1;
            use_rs1       = 1'b1;
            use_rs2       = 1'b1;
            dec_bad_enc   = (funct3 >= 3'b011);
         end
         OPC_OPIMM: begin
            dec_rw      = 1'b1;
            dec_alu_src = 1'b1;
            use_rd      = 1'b1;
            use_rs1     = 1'b1;
            dec_alu_op  = f3_to_alu(funct3, funct7[5] && (funct3 == 3'b101));
            // shift-immediate forms reserve every funct7 except the two shift variants
            if (funct3 == 3'b001 || funct3 == 3'b101)
               dec_bad_enc = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
         end
         OPC_OP: begin
            dec_rw     = 1'b1;
            use_rd     = 1'b1;
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
            dec_alu_op = f3_to_alu(funct3, funct7[5]);
         end
         OPC_BRANCH: begin
            dec_branch = 1'b1;
            use_rs1    = 1'b1;
            use_rs2    = 1'b1;
            case (funct3[2:1])
               2'b00:   dec_alu_op = ALU_SUB;
               2'b10:   dec_alu_op = ALU_SLT;
               2'b11:   dec_alu_op = ALU_SLTU;
               default: dec_bad_enc = 1'b1;
            endcase
         end
         OPC_SYSTEM: begin
            if (ENABLE_SYSTEM && inst_q == INST_EBREAK)
               dec_ebreak = 1'b1;
            else
               dec_bad_enc = 1'b1;
         end
         default: dec_bad_enc = 1'b1;
      endcase
      dec_illegal = dec_bad_enc
                  || (use_rd  && ({1'b0, rd}  >= REG_LIMIT))
                  || (use_rs1 && ({1'b0, rs1} >= REG_LIMIT))
                  || (use_rs2 && ({1'b0, rs2} >= REG_LIMIT));
   end

   // next-state logic for the sequencer, timeout counter, sticky causes and instret
   always_comb begin
      state_d   = state_q;
      tmo_d     = tmo_q;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      instret_d = instret_q;
      case (state_q)
         S_IF: begin
            if (ifu_valid) state_d = S_ID;
         end
         S_ID: begin
            if (dec_illegal) begin
               state_d   = S_HALT;
               illegal_d = 1'b1;
            end else if (dec_ebreak) begin
               state_d = S_HALT;
            end else begin
               state_d = S_EX;
            end
         end
         S_EX: begin
            tmo_d   = 8'd0;
            state_d = (mem_read_q || mem_write_q) ? S_MEM : S_WB;
         end
         S_MEM: begin
            // a completion in the final allowed cycle still counts as success
            if (lsu_done) begin
               state_d = S_WB;
               tmo_d   = 8'd0;
            end else if (tmo_q == TMO_LAST) begin
               state_d   = S_HALT;
               bus_err_d = 1'b1;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
         end
         S_WB: begin
            instret_d = instret_q + 32'd1;
            state_d   = S_IF;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IF;
      endcase
   end

   // sequencer and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IF;
         tmo_q     <= 8'd0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
         instret_q <= 32'd0;
      end else begin
         state_q   <= state_d;
         tmo_q     <= tmo_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
         instret_q <= instret_d;
      end
   end

   // instruction capture in IF and control-word load in ID; held until the next ID
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_q       <= 32'd0;
         rw_q         <= 1'b0;
         mem_read_q   <= 1'b0;
         mem_write_q  <= 1'b0;
         mem_to_reg_q <= 1'b0;
         alu_src_q    <= 1'b0;
         alu_op_q     <= ALU_ADD;
         branch_q     <= 1'b0;
         jump_q       <= 1'b0;
      end else begin
         if (state_q == S_IF && ifu_valid) inst_q <= ifu_inst;
         if (state_q == S_ID) begin
            rw_q         <= dec_rw;
            mem_read_q   <= dec_mem_read;
            mem_write_q  <= dec_mem_write;
            mem_to_reg_q <= dec_mem_to_reg;
            alu_src_q    <= dec_alu_src;
            alu_op_q     <= dec_alu_op;
            branch_q     <= dec_branch;
            jump_q       <= dec_jump;
         end
      end
   end

   // requests and strobes drop in the same cycle reset is asserted
   assign ifu_req    = (state_q == S_IF)  && !rst;
   assign lsu_req    = (state_q == S_MEM) && !rst;
   assign pc_we      = (state_q == S_WB)  && !rst;
   assign reg_write  = pc_we && rw_q;
   assign mem_read   = mem_read_q;
   assign mem_write  = mem_write_q;
   assign mem_to_reg = mem_to_reg_q;
   assign alu_src    = alu_src_q;
   assign alu_op     = alu_op_q;
   assign branch     = branch_q;
   assign jump       = jump_q;
   assign halted     = (state_q == S_HALT);
   assign illegal    = illegal_q;
   assign bus_err    = bus_err_q;
   assign instret    = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed bench for multicycle_control (two parameter sets in lockstep)
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifu_valid;
   logic [31:0] ifu_inst;
   logic        lsu_done;

   // instance A: NR_REGS=16, ENABLE_SYSTEM=1, MEM_TIMEOUT=4
   logic        ifu_req_a, lsu_req_a, reg_write_a, pc_we_a, mem_read_a, mem_write_a, mem_to_reg_a;
   logic        alu_src_a, branch_a, jump_a, halted_a, illegal_a, bus_err_a;
   logic [3:0]  alu_op_a;
   logic [31:0] instret_a;
   // instance B: NR_REGS=32, ENABLE_SYSTEM=0, MEM_TIMEOUT=255
   logic        ifu_req_b, lsu_req_b, reg_write_b, pc_we_b, mem_read_b, mem_write_b, mem_to_reg_b;
   logic        alu_src_b, branch_b, jump_b, halted_b, illegal_b, bus_err_b;
   logic [3:0]  alu_op_b;
   logic [31:0] instret_b;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [31:0] ADDI   = 32'h0050_0093;
   localparam logic [31:0] LW     = 32'h0000_A103;
   localparam logic [31:0] SW     = 32'h0020_A023;
   localparam logic [31:0] ADD16  = 32'h0020_8833;
   localparam logic [31:0] EBREAK = 32'h0010_0073;

   // legal vectors: {alu_op, alu_src, branch, jump, reg_write}
   logic [31:0] dec_inst [8] = '{32'h4020_81B3, 32'h4030_D093, 32'h0020_8063, 32'h0020_C063,
                                 32'h0020_E063, 32'h0000_00EF, 32'h0020_C1B3, 32'h0010_F093};
   logic [7:0]  dec_exp  [8] = '{{4'd1, 4'b0001}, {4'd7, 4'b1001}, {4'd1, 4'b0100}, {4'd3, 4'b0100},
                                 {4'd4, 4'b0100}, {4'd0, 4'b0011}, {4'd5, 4'b0001}, {4'd9, 4'b1001}};
   // encodings illegal in both instances
   logic [31:0] bad_inst [6] = '{32'h0200_9093, 32'h0020_A063, 32'h0000_B103,
                                 32'h0020_B023, 32'h0000_0073, 32'hFFFF_FFFF};

   multicycle_control #(.NR_REGS(16), .ENABLE_SYSTEM(1'b1), .MEM_TIMEOUT(4)) dut_a (
      .clk(clk), .rst(rst), .ifu_req(ifu_req_a), .ifu_valid(ifu_valid), .ifu_inst(ifu_inst),
      .lsu_req(lsu_req_a), .lsu_done(lsu_done), .reg_write(reg_write_a), .pc_we(pc_we_a),
      .mem_read(mem_read_a), .mem_write(mem_write_a), .mem_to_reg(mem_to_reg_a), .alu_src(alu_src_a),
      .alu_op(alu_op_a), .branch(branch_a), .jump(jump_a), .halted(halted_a), .illegal(illegal_a),
      .bus_err(bus_err_a), .instret(instret_a)
   );

   multicycle_control #(.NR_REGS(32), .ENABLE_SYSTEM(1'b0), .MEM_TIMEOUT(255)) dut_b (
      .clk(clk), .rst(rst), .ifu_req(ifu_req_b), .ifu_valid(ifu_valid), .ifu_inst(ifu_inst),
      .lsu_req(lsu_req_b), .lsu_done(lsu_done), .reg_write(reg_write_b), .pc_we(pc_we_b),
      .mem_read(mem_read_b), .mem_write(mem_write_b), .mem_to_reg(mem_to_reg_b), .alu_src(alu_src_b),
      .alu_op(alu_op_b), .branch(branch_b), .jump(jump_b), .halted(halted_b), .illegal(illegal_b),
      .bus_err(bus_err_b), .instret(instret_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   task automatic fetch(input logic [31:0] inst);
      ifu_valid = 1'b1;
      ifu_inst  = inst;
      cyc();
      ifu_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; ifu_valid = 1'b0; ifu_inst = 32'd0; lsu_done = 1'b0;
      repeat (3) cyc();
      check("rst_ifu_req", ifu_req_a, 0);
      check("rst_lsu_req", lsu_req_a, 0);
      check("rst_halted", halted_a, 0);
      check("rst_strobes", {reg_write_a, pc_we_a, illegal_a, bus_err_a}, 0);
      check("rst_instret", instret_a, 0);
      rst = 1'b0;
      #1;
      check("if_ifu_req", ifu_req_a, 1);

      // addi: WB strobes in the 4th cycle
      fetch(ADDI);
      check("addi_id_ifu_req", ifu_req_a, 0);
      cyc();
      check("addi_alu_op", alu_op_a, 0);
      check("addi_alu_src", alu_src_a, 1);
      check("addi_ex_rw", reg_write_a, 0);
      cyc();
      check("addi_wb_rw", reg_write_a, 1);
      check("addi_wb_pcwe", pc_we_a, 1);
      check("addi_wb_instret", instret_a, 0);
      cyc();
      check("addi_if_rw", reg_write_a, 0);
      check("addi_instret", instret_a, 1);
      check("addi_if_req", ifu_req_a, 1);

      // lw: lsu_done in the 3rd MEM cycle
      fetch(LW);
      cyc();
      check("lw_mem_read", mem_read_a, 1);
      check("lw_mem_to_reg", mem_to_reg_a, 1);
      check("lw_ex_lsu_req", lsu_req_a, 0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         check($sformatf("lw_mem%0d_lsu_req", i), lsu_req_a, 1);
         if (i == 2) lsu_done = 1'b1;
      end
      cyc();
      lsu_done = 1'b0;
      check("lw_wb_lsu_req", lsu_req_a, 0);
      check("lw_wb_rw", reg_write_a, 1);
      check("lw_wb_held", {mem_read_a, mem_to_reg_a}, 2'b11);
      cyc();
      check("lw_instret", instret_a, 2);
      check("lw_instret_b", instret_b, 2);

      // sw with no completion: A times out after 4 MEM cycles
      fetch(SW);
      cyc();
      check("sw_mem_write", mem_write_a, 1);
      for (int i = 0; i < 4; i++) begin
         cyc();
         check($sformatf("sw_mem%0d_lsu_req", i), lsu_req_a, 1);
         check($sformatf("sw_mem%0d_halted", i), halted_a, 0);
      end
      cyc();
      check("sw_halted", halted_a, 1);
      check("sw_bus_err", bus_err_a, 1);
      check("sw_illegal", illegal_a, 0);
      check("sw_lsu_req_after", lsu_req_a, 0);
      cyc();
      check("sw_absorbing", {halted_a, lsu_req_a, pc_we_a, ifu_req_a}, 4'b1000);
      check("sw_b_still_mem", lsu_req_b, 1);

      // reset while B sits in MEM
      rst = 1'b1;
      #1;
      check("rstmem_lsu_req_same", lsu_req_b, 0);
      cyc();
      check("rstmem_instret_b", instret_b, 0);
      check("rstmem_lsu_req_b", lsu_req_b, 0);
      check("rstmem_a_status", {halted_a, bus_err_a, illegal_a}, 0);
      check("rstmem_instret_a", instret_a, 0);
      rst = 1'b0;
      #1;
      check("rstmem_ifu_req_b", ifu_req_b, 1);

      // legal decode table
      for (int i = 0; i < 8; i++) begin
         fetch(dec_inst[i]);
         cyc();
         check($sformatf("dec%0d_alu_op", i), alu_op_a, dec_exp[i][7:4]);
         check($sformatf("dec%0d_flags", i), {alu_src_a, branch_a, jump_a}, dec_exp[i][3:1]);
         check($sformatf("dec%0d_alu_op_b", i), alu_op_b, dec_exp[i][7:4]);
         cyc();
         check($sformatf("dec%0d_rw", i), reg_write_a, dec_exp[i][0]);
         check($sformatf("dec%0d_pcwe", i), pc_we_a, 1);
         cyc();
      end
      check("dec_instret", instret_a, 8);

      // x16 is out of range only for NR_REGS=16
      fetch(ADD16);
      cyc();
      check("x16_halted_a", halted_a, 1);
      check("x16_illegal_a", illegal_a, 1);
      check("x16_halted_b", halted_b, 0);
      cyc();
      check("x16_rw_b", reg_write_b, 1);
      check("x16_pcwe_a", pc_we_a, 0);
      cyc();
      check("x16_instret_b", instret_b, 9);
      check("x16_instret_a", instret_a, 8);
      check("x16_ifu_req_a", ifu_req_a, 0);
      do_reset();

      // ebreak: clean halt with SYSTEM enabled, illegal otherwise
      fetch(EBREAK);
      cyc();
      check("ebreak_halted_a", halted_a, 1);
      check("ebreak_illegal_a", illegal_a, 0);
      check("ebreak_halted_b", halted_b, 1);
      check("ebreak_illegal_b", illegal_b, 1);
      cyc();
      check("ebreak_no_retire", {pc_we_a, ifu_req_a}, 0);
      check("ebreak_instret", instret_a, 0);
      do_reset();

      // illegal encodings
      for (int i = 0; i < 6; i++) begin
         fetch(bad_inst[i]);
         cyc();
         check($sformatf("bad%0d_a", i), {halted_a, illegal_a}, 2'b11);
         check($sformatf("bad%0d_b", i), {halted_b, illegal_b}, 2'b11);
         do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
